// File: rtl/clk_branch_seq_pkg.sv
// Shared types and default sizes for the clock-branch sequencer.
//   state_e    : sequencer states
//   NUM_BR_DEF : default number of gated clock-inverter branches
//   STAG_W_DEF : default width of the stagger interval
//   is_ramp()  : true while the sequencer is stepping branches
package clk_branch_seq_pkg;

  localparam int unsigned NUM_BR_DEF = 4;
  localparam int unsigned STAG_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_RAMP_UP = 2'd1,
    ST_ON      = 2'd2,
    ST_RAMP_DN = 2'd3
  } state_e;

  function automatic logic is_ramp(state_e s);
    return (s == ST_RAMP_UP) || (s == ST_RAMP_DN);
  endfunction

endpackage

// File: rtl/clk_branch_seq_timer.sv
// Stagger interval counter: load, decrement toward zero, registered zero flag.
//   clk_i, rst_n_i : clock, async active-low reset (counter cleared)
//   load_i         : load load_val_i (has priority over dec_i)
//   dec_i          : decrement while nonzero
//   load_val_i     : reload value
//   zero_o         : counter is zero
module clk_branch_seq_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         zero_q;

  // Next count
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Zero flag tracks the next count so it is valid in the same cycle as cnt_q
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= (cnt_d == '0);
    end
  end

  assign zero_o = zero_q;

endmodule

// File: rtl/clk_branch_seq.sv
// Staggered power sequencer for gated clock-inverter branches.
// Ramps a thermometer-coded enable vector up/down one branch per stagger
// interval in response to a level request.
//   CLK     : clock (rising edge)
//   RN      : async active-low reset
//   req     : 1 = all branches on, 0 = all branches off
//   stagger : idle cycles between steps, sampled at each reload
//   br_en   : branch enables, thermometer-coded from bit 0
//   ack     : high in ON
//   busy    : high in RAMP_UP / RAMP_DN
// Build option: CLK_BRANCH_SEQ_FAST_DN_EN -- entering RAMP_DN clears all
// branches at once; OFF follows after the stagger interval.
module clk_branch_seq
  import clk_branch_seq_pkg::*;
#(
  parameter int unsigned NUM_BR = NUM_BR_DEF,
  parameter int unsigned STAG_W = STAG_W_DEF
) (
  input  logic              CLK,
  input  logic              RN,
  input  logic              req,
  input  logic [STAG_W-1:0] stagger,
  output logic [NUM_BR-1:0] br_en,
  output logic              ack,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [NUM_BR-1:0] br_en_q, br_en_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              tmr_load, tmr_dec, tmr_zero;

  clk_branch_seq_timer #(
    .W (STAG_W)
  ) u_timer (
    .clk_i      (CLK),
    .rst_n_i    (RN),
    .load_i     (tmr_load),
    .dec_i      (tmr_dec),
    .load_val_i (stagger),
    .zero_o     (tmr_zero)
  );

  // Next state, enables and timer control; a req reversal beats a pending step
  always_comb begin
    state_d  = state_q;
    br_en_d  = br_en_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    unique case (state_q)
      ST_OFF: begin
        if (req) begin
          state_d  = ST_RAMP_UP;
          br_en_d  = NUM_BR'(1);
          tmr_load = 1'b1;
        end
      end
      ST_RAMP_UP: begin
        if (!req) begin
          state_d  = ST_RAMP_DN;
          tmr_load = 1'b1;
`ifdef CLK_BRANCH_SEQ_FAST_DN_EN
          br_en_d  = '0;
`endif
        end else if (!tmr_zero) begin
          tmr_dec = 1'b1;
        end else if (br_en_q[NUM_BR-1]) begin
          state_d = ST_ON;
        end else begin
          br_en_d  = {br_en_q[NUM_BR-2:0], 1'b1};
          tmr_load = 1'b1;
        end
      end
      ST_ON: begin
        if (!req) begin
          state_d  = ST_RAMP_DN;
          tmr_load = 1'b1;
`ifdef CLK_BRANCH_SEQ_FAST_DN_EN
          br_en_d  = '0;
`else
          br_en_d  = {1'b0, br_en_q[NUM_BR-1:1]};
`endif
        end
      end
      ST_RAMP_DN: begin
        if (req) begin
          state_d  = ST_RAMP_UP;
          tmr_load = 1'b1;
        end else if (!tmr_zero) begin
          tmr_dec = 1'b1;
        end else if (br_en_q == '0) begin
          state_d = ST_OFF;
        end else begin
          br_en_d  = {1'b0, br_en_q[NUM_BR-1:1]};
          tmr_load = 1'b1;
        end
      end
      default: state_d = ST_OFF;
    endcase
    ack_d  = (state_d == ST_ON);
    busy_d = is_ramp(state_d);
  end

  // State and registered outputs
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= ST_OFF;
      br_en_q <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      br_en_q <= br_en_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign br_en = br_en_q;
  assign ack   = ack_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_clk_branch_seq.sv
// Directed bench for clk_branch_seq (NUM_BR=4, STAG_W=4). Expected output
// per cycle is derived from the timing formulas and queued; each clock the
// front entry is popped and compared with the DUT.
// Honours CLK_BRANCH_SEQ_FAST_DN_EN for the descent expectations.
module tb_clk_branch_seq;

  localparam int unsigned NB = 4;
  localparam int unsigned SW = 4;

  typedef struct {
    logic [NB-1:0] br;
    logic          ack;
    logic          busy;
    string         tag;
  } exp_t;

  logic          CLK;
  logic          RN;
  logic          req;
  logic [SW-1:0] stagger;
  logic [NB-1:0] br_en;
  logic          ack;
  logic          busy;

  exp_t sb_q[$];
  int   n_cmp;
  int   n_err;

  clk_branch_seq #(
    .NUM_BR (NB),
    .STAG_W (SW)
  ) dut (
    .CLK     (CLK),
    .RN      (RN),
    .req     (req),
    .stagger (stagger),
    .br_en   (br_en),
    .ack     (ack),
    .busy    (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [NB-1:0] therm(input int n);
    logic [NB-1:0] v;
    v = '0;
    for (int i = 0; i < int'(NB); i++) if (i < n) v[i] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [NB-1:0] br, input logic a, input logic b, input string tag);
    exp_t e;
    e.br = br; e.ack = a; e.busy = b; e.tag = tag;
    sb_q.push_back(e);
  endtask

  // One clock; compare the oldest queued expectation
  task automatic step();
    exp_t e;
    @(posedge CLK);
    #1;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 8'(1), 8'(0));
    end else begin
      e = sb_q.pop_front();
      chk({e.tag, " br_en"}, 8'(br_en), 8'(e.br));
      chk({e.tag, " ack"},   8'(ack),   8'(e.ack));
      chk({e.tag, " busy"},  8'(busy),  8'(e.busy));
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " br_en"}, 8'(br_en), 8'(0));
    chk({tag, " ack"},   8'(ack),   8'(0));
    chk({tag, " busy"},  8'(busy),  8'(0));
  endtask

  // Branch k on at n = 1+k(S+1); ON at n = 1+NB(S+1)
  task automatic run_up(input int s, input int cnt, input string nm);
    int  k;
    logic on;
    for (int n = 1; n <= cnt; n++) begin
      k = (n - 1) / (s + 1) + 1;
      if (k > int'(NB)) k = int'(NB);
      on = (n >= 1 + int'(NB) * (s + 1));
      push(therm(k), on, !on, $sformatf("%s n=%0d", nm, n));
      step();
    end
  endtask

  task automatic run_dn(input int s, input int cnt, input string nm);
    int  c;
    logic off;
    for (int n = 1; n <= cnt; n++) begin
`ifdef CLK_BRANCH_SEQ_FAST_DN_EN
      c   = int'(NB);
      off = (n >= 1 + (s + 1));
`else
      c = (n - 1) / (s + 1) + 1;
      if (c > int'(NB)) c = int'(NB);
      off = (n >= 1 + int'(NB) * (s + 1));
`endif
      push(therm(int'(NB) - c), 1'b0, !off, $sformatf("%s n=%0d", nm, n));
      step();
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    RN      = 1'b1;
    req     = 1'b0;
    stagger = SW'(2);

    // Reset state, asynchronous and held across edges
    #2 RN = 1'b0;
    #1 chk_zero("reset_async");
    repeat (2) @(posedge CLK);
    #1 chk_zero("reset_held");

    // Power-up, S=2; first edge after release samples req
    @(negedge CLK);
    RN  = 1'b1;
    req = 1'b1;
    run_up(2, 14, "pwr_up");

    // Power-down from ON
`ifdef CLK_BRANCH_SEQ_FAST_DN_EN
    stagger = SW'(3);
    req = 1'b0;
    run_dn(3, 8, "fast_dn");
`else
    stagger = SW'(2);
    req = 1'b0;
    run_dn(2, 14, "pwr_dn");
`endif

    // Reversal with S=0: req high for two edges, then low
    stagger = SW'(0);
    req = 1'b1;
    push(4'b0001, 1'b0, 1'b1, "rev n=1"); step();
    push(4'b0011, 1'b0, 1'b1, "rev n=2"); step();
    req = 1'b0;
`ifdef CLK_BRANCH_SEQ_FAST_DN_EN
    push(4'b0000, 1'b0, 1'b1, "rev n=3"); step();
    push(4'b0000, 1'b0, 1'b0, "rev n=4"); step();
    push(4'b0000, 1'b0, 1'b0, "rev n=5"); step();
    push(4'b0000, 1'b0, 1'b0, "rev n=6"); step();
`else
    push(4'b0011, 1'b0, 1'b1, "rev n=3"); step();
    push(4'b0001, 1'b0, 1'b1, "rev n=4"); step();
    push(4'b0000, 1'b0, 1'b1, "rev n=5"); step();
    push(4'b0000, 1'b0, 1'b0, "rev n=6"); step();
`endif

    // Mid-ramp reset at 0111, then a fresh start
    stagger = SW'(1);
    req = 1'b1;
    run_up(1, 5, "pre_rst");
    RN = 1'b0;
    #1 chk_zero("mid_rst");
    @(negedge CLK);
    RN = 1'b1;
    run_up(1, 4, "post_rst");

    // Stagger 1 -> 5 mid-ramp takes effect only at the next reload
    RN  = 1'b0;
    req = 1'b0;
    @(negedge CLK);
    chk_zero("stag_rst");
    RN      = 1'b1;
    req     = 1'b1;
    stagger = SW'(1);
    push(4'b0001, 1'b0, 1'b1, "stag n=1"); step();
    stagger = SW'(5);
    for (int n = 2; n <= 9; n++) begin
      push((n < 3) ? 4'b0001 : ((n < 9) ? 4'b0011 : 4'b0111), 1'b0, 1'b1,
           $sformatf("stag n=%0d", n));
      step();
    end

    chk("sb_drained", 8'(sb_q.size()), 8'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/clk_branch_seq.md
CLK_BRANCH_SEQ -- requirements
Module: clk_branch_seq

Interface
REQ-001 SHALL have parameter NUM_BR, default 4, number of gated clock-inverter branches sequenced (range 2..8).
REQ-002 SHALL have parameter STAG_W, default 4, width of the stagger-interval input.
REQ-003 SHALL have port CLK, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port RN, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port req, input, 1 bit, level request: 1 = all branches on, 0 = all branches off.
REQ-006 SHALL have port stagger, input, STAG_W bits: idle cycles S between successive steps; sampled at every reload.
REQ-007 SHALL have port br_en, output, NUM_BR bits: branch enables, thermometer-coded from bit 0.
REQ-008 SHALL have port ack, output, 1 bit: 1 only in state ON.
REQ-009 SHALL have port busy, output, 1 bit: 1 in RAMP_UP or RAMP_DN.

Function
REQ-010 SHALL implement states OFF, RAMP_UP, ON, RAMP_DN.
REQ-011 SHALL keep br_en thermometer-coded at all times; it changes by at most one bit per cycle, except under REQ-033.
REQ-012 SHALL move OFF to RAMP_UP when req=1 is sampled at edge t; at t+1: br_en bit 0 set, counter loaded with stagger.
REQ-013 SHALL, in RAMP_UP, decrement the counter while nonzero; at zero, set the next br_en bit and reload.
REQ-014 SHALL set branch k (0-based) at t+1+k(S+1); enter ON with ack=1 at t+1+NUM_BR(S+1).
REQ-015 SHALL treat S=0 as one step per cycle.
REQ-016 SHALL move ON to RAMP_DN when req=0 is sampled at edge u; at u+1: ack=0, highest set bit cleared, counter reloaded.
REQ-017 SHALL, in RAMP_DN, clear the highest set bit each time the counter reaches zero, then reload.
REQ-018 SHALL give br_en=0 at u+1+(NUM_BR-1)(S+1) and OFF at u+1+NUM_BR(S+1).
REQ-019 SHALL, on req=0 in RAMP_UP, go to RAMP_DN at the next edge; br_en held and counter reloaded in that cycle; descent continues from the current level.
REQ-020 SHALL, on req=1 in RAMP_DN, go to RAMP_UP at the next edge likewise; ascent continues from the current level.
REQ-021 SHALL, on a req change in the same cycle a step would occur, apply the reversal and suppress the step.
REQ-022 SHALL ignore stagger changes until the next reload.
REQ-023 SHALL ignore req pulses shorter than one cycle only in the sense that sampling is synchronous; req is assumed synchronous to CLK.

Reset
REQ-030 SHALL, on RN low, asynchronously force state OFF, br_en=0, ack=0, busy=0, counter=0.
REQ-031 SHALL, on RN release, sample req at the first rising edge; a mid-ramp reset abandons the ramp and does not resume it.

Configuration
REQ-033 SHALL, with CLK_BRANCH_SEQ_FAST_DN_EN defined, make entry to RAMP_DN clear all br_en bits at once and enter OFF S+1 cycles later.
REQ-034 SHALL, without CLK_BRANCH_SEQ_FAST_DN_EN, use the staggered descent of REQ-016..018.

Structure
REQ-040 SHALL place the state enum and default NUM_BR/STAG_W constants in package clk_branch_seq_pkg.
REQ-041 SHALL implement the stagger counter as sub-module clk_branch_seq_timer (load, decrement, zero flag).

Verification
REQ-050 SHALL verify power-up: NUM_BR=4, S=2, req rises at t -> br_en 0001@t+1, 0011@t+4, 0111@t+7, 1111@t+10, ack=1@t+13, busy=0@t+13.
REQ-051 SHALL verify power-down: from ON, S=2, req falls at u -> ack=0 and 0111@u+1, 0011@u+4, 0001@u+7, 0000@u+10, OFF@u+13.
REQ-052 SHALL verify reversal: S=0, req high for 2 cycles then low -> br_en reaches 0011, falls 0001 then 0000, ack never 1.
REQ-053 SHALL verify mid-ramp reset: RN low at br_en=0111 -> all outputs 0 immediately; after release with req=1, restarts at 0001.
REQ-054 SHALL verify FAST_DN: with macro defined, S=3, req falls in ON -> br_en=0000 at u+1, OFF at u+5.
REQ-055 SHALL verify stagger change: S set 1 to 5 mid-ramp -> new interval used only after the next reload.
